mipi_csi_rx_header_ecc: RTL and testbench
=========================================

// Module: mipi_csi_rx_header_ecc
// PURPOSE
//  MIPI CSI-2 RX packet-header ECC checker/corrector. Takes a 32-bit header and recomputes the 6-bit Hamming ECC.
//  Corrects any single-bit error and detects double-bit errors.
//  Emits the word count, virtual channel and data type, plus a one-hot error status.
//  Sits between the lane-merge/byte aligner and the packet decoder FSM.
// PARAMETERS
//  none (header format fixed by CSI-2 v1.x)
// PORTS
//  clk_i              in   1   clock
//  reset_n_i          in   1   asynchronous reset, active-low
//  packet_header_i    in   32  {DI[31:24], WC_LS[23:16], WC_MS[15:8], ECC[7:0]}
//  packet_length_o    out  16  corrected word count {WC_MS, WC_LS}
//  vc_id_o            out  2   corrected DI[7:6]
//  data_type_o        out  6   corrected DI[5:0]
//  no_error_o         out  1   syndrome zero
//  corrected_error_o  out  1   single-bit error corrected
//  error_o            out  1   uncorrectable error
// BEHAVIOUR
//  - Data vector D[23:0] = {WC_MS, WC_LS, DI}, i.e. D[7:0]=hdr[31:24], D[15:8]=hdr[23:16], D[23:16]=hdr[15:8].
//  - Parity equations, CSI-2 v1.x:
//    P0=D0^1^2^4^5^7^10^11^13^16^20^21^22^23
//    P1=D0^1^3^4^6^8^10^12^14^17^20^21^22^23
//    P2=D0^2^3^5^6^9^11^12^15^18^20^21^22
//    P3=D1^2^3^7^8^9^13^14^15^19^20^21^23
//    P4=D4^5^6^7^8^9^16^17^18^19^20^22^23
//    P5=D10^11^12^13^14^15^16^17^18^19^21^22^23
//  - ECC[7:6] are ignored (reserved). syndrome[5:0] = P[5:0] ^ hdr[5:0].
//  - syndrome==0: no_error_o=1; data passes through unchanged.
//  - syndrome equals the parity column of data bit Dk: flip Dk; corrected_error_o=1.
//  - syndrome one-hot (ECC bit error): data unchanged; corrected_error_o=1.
//  - Any other syndrome: error_o=1; data passes through uncorrected.
//  - Exactly one status flag is high per registered result.
//  - The 24 data-bit columns are distinct, non-zero and not one-hot. Mapping comes from a LUT in the package.
//  - Combinational decode feeds output registers: latency 1 cycle. A new header is accepted every cycle (no handshake).
//  - Reset (async assert, sync release): every output = 0, including all three flags.
//  - First valid result appears on the first rising edge after reset release.
//  - Errors of 3+ bits may alias to a valid column and are miscorrected. This is inherent to the code and is not flagged.
// CONFIGURATION
//  MIPI_CSI_RX_HEADER_ECC_PIPE_EN
//    defined: adds an input register on packet_header_i; latency 2 cycles. Reset clears it to 0.
//    undefined: latency 1 cycle.
//  Decode function is identical in both builds.
// STRUCTURE
//  Package mipi_csi_rx_pkg:
//    - ECC parity-mask constants (6 x 24-bit)
//    - syndrome->bit-index LUT / function
//    - csi_dt_e data-type typedef
//    - header field-position localparams
//  Sub-module mipi_csi_rx_ecc_gen: combinational 24-bit -> 6-bit parity generator. Reusable by the TX model.
// TESTING
//  1 hdr=32'h37F0013F -> after latency: no_error=1; len=16'h01F0, vc=0, dt=6'h37.
//  2 hdr=32'h27F0013F (D4 flipped, syndrome 6'h13) -> corrected_error=1; len=16'h01F0, vc=0, dt=6'h37.
//  3 hdr=32'h07F0013F (D4+D5 flipped, syndrome 6'h06) -> error=1; dt=6'h07, len=16'h01F0.
//  4 hdr=32'h00F0013F (5-bit error, syndrome 6'h07 aliases D0) -> corrected_error=1; dt=6'h01 (miscorrection).
//  5 hdr=32'h37F0013E (ECC bit0 flipped) -> corrected_error=1; len=16'h01F0, dt=6'h37.
//  6 Reset asserted mid-stream -> all outputs 0 immediately.
//    Back-to-back headers on consecutive cycles -> one result per cycle, in order.
//    Exhaustive: all 24+6 single-bit flips of random headers corrected.

Source files
------------

// File: rtl/mipi_csi_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : mipi_csi_rx_pkg                                        |
// | Description : CSI-2 header field positions, ECC masks, syndrome LUT  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package mipi_csi_rx_pkg;

    localparam int HDR_DI_MSB    = 31;
    localparam int HDR_DI_LSB    = 24;
    localparam int HDR_WCLS_MSB  = 23;
    localparam int HDR_WCLS_LSB  = 16;
    localparam int HDR_WCMS_MSB  = 15;
    localparam int HDR_WCMS_LSB  = 8;
    localparam int HDR_ECC_MSB   = 5;
    localparam int HDR_ECC_LSB   = 0;
    localparam int HDR_RSVD_MSB  = 7;
    localparam int HDR_RSVD_LSB  = 6;

    localparam int ECC_DATA_W    = 24;
    localparam int ECC_PAR_W     = 6;

    // Row i selects the data bits that feed parity bit Pi.
    localparam logic [ECC_PAR_W-1:0][ECC_DATA_W-1:0] ECC_MASK = {
        24'hEFFC00,  // P5
        24'hDF03F0,  // P4
        24'hB8E38E,  // P3
        24'h749A6D,  // P2
        24'hF2555B,  // P1
        24'hF12CB7   // P0
    };

    typedef enum logic [5:0] {
        DT_FS       = 6'h00,
        DT_FE       = 6'h01,
        DT_LS       = 6'h02,
        DT_LE       = 6'h03,
        DT_EMBEDDED = 6'h12,
        DT_YUV422_8 = 6'h1E,
        DT_RGB888   = 6'h24,
        DT_RAW8     = 6'h2A,
        DT_RAW10    = 6'h2B,
        DT_RAW12    = 6'h2C
    } csi_dt_e;

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } ecc_lut_t;

    // Maps a syndrome to the data bit whose parity column it equals.
    function automatic ecc_lut_t syndrome_to_bit(input logic [ECC_PAR_W-1:0] syn);
        ecc_lut_t r;
        r.hit = 1'b1;
        case (syn)
            6'h07:   r.idx = 5'd0;
            6'h0B:   r.idx = 5'd1;
            6'h0D:   r.idx = 5'd2;
            6'h0E:   r.idx = 5'd3;
            6'h13:   r.idx = 5'd4;
            6'h15:   r.idx = 5'd5;
            6'h16:   r.idx = 5'd6;
            6'h19:   r.idx = 5'd7;
            6'h1A:   r.idx = 5'd8;
            6'h1C:   r.idx = 5'd9;
            6'h23:   r.idx = 5'd10;
            6'h25:   r.idx = 5'd11;
            6'h26:   r.idx = 5'd12;
            6'h29:   r.idx = 5'd13;
            6'h2A:   r.idx = 5'd14;
            6'h2C:   r.idx = 5'd15;
            6'h31:   r.idx = 5'd16;
            6'h32:   r.idx = 5'd17;
            6'h34:   r.idx = 5'd18;
            6'h38:   r.idx = 5'd19;
            6'h1F:   r.idx = 5'd20;
            6'h2F:   r.idx = 5'd21;
            6'h37:   r.idx = 5'd22;
            6'h3B:   r.idx = 5'd23;
            default: begin
                r.hit = 1'b0;
                r.idx = 5'd0;
            end
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mipi_csi_rx_ecc_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mipi_csi_rx_ecc_gen                                    |
// | Description : combinational 24-bit -> 6-bit CSI-2 header parity      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module mipi_csi_rx_ecc_gen
    import mipi_csi_rx_pkg::*;
(
    input  logic [ECC_DATA_W-1:0] data_i,
    output logic [ECC_PAR_W-1:0]  parity_o
);

    for (genvar i = 0; i < ECC_PAR_W; i++) begin : g_parity
        assign parity_o[i] = ^(data_i & ECC_MASK[i]);
    end

endmodule
`default_nettype wire

// File: rtl/mipi_csi_rx_header_ecc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mipi_csi_rx_header_ecc                                 |
// | Description : CSI-2 RX header ECC check/correct, registered outputs. |
// |               MIPI_CSI_RX_HEADER_ECC_PIPE_EN adds an input register. |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module mipi_csi_rx_header_ecc
    import mipi_csi_rx_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [31:0] packet_header_i,
    output logic [15:0] packet_length_o,
    output logic [1:0]  vc_id_o,
    output logic [5:0]  data_type_o,
    output logic        no_error_o,
    output logic        corrected_error_o,
    output logic        error_o
);

    logic [31:0]           w_hdr;
    logic [ECC_DATA_W-1:0] w_data;
    logic [ECC_DATA_W-1:0] w_fixed;
    logic [ECC_PAR_W-1:0]  w_parity;
    logic [ECC_PAR_W-1:0]  w_syndrome;
    ecc_lut_t              w_lut;
    logic                  w_no_err;
    logic                  w_corr;
    logic                  w_err;
    logic                  w_unused_rsvd;

`ifdef MIPI_CSI_RX_HEADER_ECC_PIPE_EN
    logic [31:0] r_hdr;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_hdr <= '0;
        end else begin
            r_hdr <= packet_header_i;
        end
    end

    assign w_hdr = r_hdr;
`else
    assign w_hdr = packet_header_i;
`endif

    // Reserved ECC bits carry no information.
    assign w_unused_rsvd = ^w_hdr[HDR_RSVD_MSB:HDR_RSVD_LSB];

    assign w_data = {w_hdr[HDR_WCMS_MSB:HDR_WCMS_LSB],
                     w_hdr[HDR_WCLS_MSB:HDR_WCLS_LSB],
                     w_hdr[HDR_DI_MSB:HDR_DI_LSB]};

    mipi_csi_rx_ecc_gen u_ecc_gen (
        .data_i   (w_data),
        .parity_o (w_parity)
    );

    assign w_syndrome = w_parity ^ w_hdr[HDR_ECC_MSB:HDR_ECC_LSB];
    assign w_lut      = syndrome_to_bit(w_syndrome);

    always_comb begin
        w_fixed  = w_data;
        w_no_err = 1'b0;
        w_corr   = 1'b0;
        w_err    = 1'b0;
        if (w_syndrome == '0) begin
            w_no_err = 1'b1;
        end else if (w_lut.hit) begin
            w_fixed = w_data ^ (24'd1 << w_lut.idx);
            w_corr  = 1'b1;
        end else if ($onehot(w_syndrome)) begin
            // Error confined to the ECC byte: payload already correct.
            w_corr = 1'b1;
        end else begin
            w_err = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            packet_length_o   <= '0;
            vc_id_o           <= '0;
            data_type_o       <= '0;
            no_error_o        <= 1'b0;
            corrected_error_o <= 1'b0;
            error_o           <= 1'b0;
        end else begin
            packet_length_o   <= w_fixed[23:8];
            vc_id_o           <= w_fixed[7:6];
            data_type_o       <= w_fixed[5:0];
            no_error_o        <= w_no_err;
            corrected_error_o <= w_corr;
            error_o           <= w_err;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mipi_csi_rx_header_ecc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mipi_csi_rx_header_ecc                              |
// | Description : randomized self-checking bench for the header ECC      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_mipi_csi_rx_header_ecc;

`ifdef MIPI_CSI_RX_HEADER_ECC_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        reset_n;
    logic [31:0] hdr;
    logic [15:0] len;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic        no_err, corr_err, err;

    int checks   = 0;
    int failures = 0;

    logic [26:0] exp_q[$];
    string       tag_q[$];

    mipi_csi_rx_header_ecc dut (
        .clk_i             (clk),
        .reset_n_i         (reset_n),
        .packet_header_i   (hdr),
        .packet_length_o   (len),
        .vc_id_o           (vc),
        .data_type_o       (dt),
        .no_error_o        (no_err),
        .corrected_error_o (corr_err),
        .error_o           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Parity straight from the CSI-2 equations.
    function automatic logic [5:0] m_parity(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    function automatic logic [23:0] m_data(input logic [31:0] h);
        return {h[15:8], h[23:16], h[31:24]};
    endfunction

    // Packed result: {len[15:0], vc[1:0], dt[5:0], no_err, corr, err}.
    function automatic logic [26:0] pack(input logic [23:0] d, input logic [2:0] f);
        return {d[23:8], d[7:6], d[5:0], f};
    endfunction

    // Decode by searching for the data bit whose single-bit error would give this syndrome.
    function automatic logic [26:0] m_decode(input logic [31:0] h);
        logic [23:0] d;
        logic [5:0]  syn;
        logic [2:0]  f;
        bit          found;
        d     = m_data(h);
        syn   = m_parity(d) ^ h[5:0];
        found = 1'b0;
        if (syn == 6'd0) begin
            f = 3'b100;
        end else begin
            for (int k = 0; k < 24; k++) begin
                if (!found && m_parity(24'd1 << k) == syn) begin
                    d[k]  = ~d[k];
                    found = 1'b1;
                end
            end
            if (found || $countones(syn) == 1) f = 3'b010;
            else                               f = 3'b001;
        end
        return pack(d, f);
    endfunction

    function automatic logic [31:0] make_valid(input logic [31:0] r);
        logic [31:0] h;
        h      = r;
        h[5:0] = m_parity(m_data(r));
        return h;
    endfunction

    function automatic logic [26:0] observed();
        return {len, vc, dt, no_err, corr_err, err};
    endfunction

    task automatic step(input logic [31:0] h, input logic [26:0] exp, input string tag);
        @(negedge clk);
        if (exp_q.size() >= LAT) check(tag_q.pop_front(), 32'(observed()), 32'(exp_q.pop_front()));
        hdr = h;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic flush();
        repeat (LAT) begin
            @(negedge clk);
            if (exp_q.size() > 0) check(tag_q.pop_front(), 32'(observed()), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin
        logic [31:0] base, h;
        reset_n = 1'b0;
        hdr     = 32'h0;
        repeat (3) @(posedge clk);
        #1 check("reset_state", 32'(observed()), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors with hand-derived results.
        step(32'h37F0013F, {16'h01F0, 2'd0, 6'h37, 3'b100}, "dir_clean");
        step(32'h27F0013F, {16'h01F0, 2'd0, 6'h37, 3'b010}, "dir_d4");
        step(32'h07F0013F, {16'h01F0, 2'd0, 6'h07, 3'b001}, "dir_d4d5");
        step(32'h00F0013F, {16'h01F0, 2'd0, 6'h01, 3'b010}, "dir_alias");
        step(32'h37F0013E, {16'h01F0, 2'd0, 6'h37, 3'b010}, "dir_ecc0");
        step(32'h37F001FF, {16'h01F0, 2'd0, 6'h37, 3'b100}, "dir_rsvd");

        // Every correctable single-bit flip, plus reserved-bit flips, of random valid headers.
        for (int n = 0; n < 8; n++) begin
            base = make_valid($urandom());
            for (int b = 0; b < 32; b++) begin
                h = base ^ (32'd1 << b);
                if (b == 6 || b == 7) step(h, pack(m_data(base), 3'b100), "flip_rsvd");
                else                  step(h, pack(m_data(base), 3'b010), "flip_single");
            end
        end

        // Random headers, valid or corrupted by 0..3 bit flips, back to back.
        for (int n = 0; n < 400; n++) begin
            h = make_valid($urandom());
            for (int e = $urandom_range(0, 3); e > 0; e--) h ^= (32'd1 << $urandom_range(0, 31));
            if (n % 5 == 0) h = $urandom();
            step(h, m_decode(h), "random");
        end

        // Asynchronous reset in mid-stream.
        for (int n = 0; n < 5; n++) begin
            h = $urandom();
            step(h, m_decode(h), "pre_reset");
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check("async_reset", 32'(observed()), 32'h0);
        exp_q.delete();
        tag_q.delete();
        @(posedge clk);
        #1 check("reset_hold", 32'(observed()), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 0; n < 50; n++) begin
            h = make_valid($urandom()) ^ (($urandom_range(0, 1) == 1) ? (32'd1 << $urandom_range(8, 31)) : 32'd0);
            step(h, m_decode(h), "post_reset");
        end
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
